// File: rtl/mhp_pkg.sv
// Shared MHP protocol constants, header layout and TX state encoding.
// Imported by the transmit path and the receive-side checker.
package mhp_pkg;

  localparam int unsigned MHP_HDR_LEN     = 7;
  localparam int unsigned MHP_SCS_LEN     = 2;
  localparam int unsigned ETH_MIN_PAYLOAD = 46;

  localparam int unsigned DIR_BIT  = 7;
  localparam int unsigned TYPE_MSB = 6;
  localparam int unsigned TYPE_LSB = 0;

  localparam logic [2:0] HDR_DST_HI = 3'd0;
  localparam logic [2:0] HDR_DST_LO = 3'd1;
  localparam logic [2:0] HDR_SRC_HI = 3'd2;
  localparam logic [2:0] HDR_SRC_LO = 3'd3;
  localparam logic [2:0] HDR_LEN_HI = 3'd4;
  localparam logic [2:0] HDR_LEN_LO = 3'd5;
  localparam logic [2:0] HDR_DTYPE  = 3'd6;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PREQ = 3'd2;
  localparam logic [2:0] S_PCAP = 3'd3;
  localparam logic [2:0] S_PWR  = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;
  localparam logic [2:0] S_PAD  = 3'd6;
  localparam logic [2:0] S_FIN  = 3'd7;

  typedef struct packed {
    logic [15:0] dst;
    logic [15:0] src;
    logic [7:0]  d_type;
    logic [15:0] len;
  } mhp_hdr_t;

  function automatic logic [7:0] hdr_byte(input mhp_hdr_t h, input logic [2:0] idx);
    logic [7:0] b;
    b = '0;
    case (idx)
      HDR_DST_HI: b = h.dst[15:8];
      HDR_DST_LO: b = h.dst[7:0];
      HDR_SRC_HI: b = h.src[15:8];
      HDR_SRC_LO: b = h.src[7:0];
      HDR_LEN_HI: b = h.len[15:8];
      HDR_LEN_LO: b = h.len[7:0];
      HDR_DTYPE:  b = {h.d_type[DIR_BIT], h.d_type[TYPE_MSB:TYPE_LSB]};
      default:    b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mhp_scs_acc.sv
// 16-bit modulo-2^16 byte-sum accumulator for the MHP SCS field.
// Clear has priority over add.
module mhp_scs_acc (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_sum
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum <= '0;
    end else if (i_clr) begin
      o_sum <= '0;
    end else if (i_add) begin
      o_sum <= o_sum + {8'h00, i_byte};
    end
  end

endmodule

// File: rtl/mhp_tx.sv
// MHP transmit framer: header, payload, SCS trailer and zero padding,
// written one byte per accepted cycle into the Ethernet write FIFO.
module mhp_tx
  import mhp_pkg::*;
#(
  parameter int unsigned MIN_FRAME = ETH_MIN_PAYLOAD,
  parameter int unsigned MAX_LEN   = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_send,
  input  logic [15:0] i_dst_addr,
  input  logic [15:0] i_src_addr,
  input  logic [7:0]  i_d_type,
  input  logic [15:0] i_len,
  input  logic        i_pready,
  output logic        o_preq,
  input  logic [7:0]  i_pdata,
  input  logic        i_wready,
  output logic        o_wvalid,
  output logic [7:0]  o_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  logic [2:0]  r_state;
  mhp_hdr_t    r_hdr;
  logic [2:0]  r_idx;
  logic [15:0] r_cnt;
  logic [15:0] r_pcnt;
  logic [7:0]  r_pbyte;
  logic        r_wvalid;
  logic [7:0]  r_wdata;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [15:0] w_sum;
  logic [15:0] w_cnt_nxt;
  logic [7:0]  w_hdr_byte;
  logic [7:0]  w_scs_byte;
  logic [7:0]  w_acc_byte;
  logic        w_len_ok;
  logic        w_accept;
  logic        w_acc_add;

  assign w_len_ok   = (i_len <= 16'(MAX_LEN));
  assign w_accept   = (r_state == S_IDLE) && i_send && w_len_ok;
  assign w_hdr_byte = hdr_byte(r_hdr, r_idx);
  assign w_scs_byte = (r_idx == '0) ? w_sum[15:8] : w_sum[7:0];
  assign w_cnt_nxt  = r_cnt + 16'd1;
  // Header bytes enter the sum as they are written; payload as it is captured.
  assign w_acc_add  = ((r_state == S_HDR) && i_wready) || (r_state == S_PCAP);
  assign w_acc_byte = (r_state == S_PCAP) ? i_pdata : w_hdr_byte;

  // Combinational strobe so the FIFO pops on the same edge we move to PCAP.
  assign o_preq   = (r_state == S_PREQ) && i_pready;
  assign o_wvalid = r_wvalid;
  assign o_wdata  = r_wdata;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_err    = r_err;

  mhp_scs_acc u_scs (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_accept),
    .i_add   (w_acc_add),
    .i_byte  (w_acc_byte),
    .o_sum   (w_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_hdr    <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_pbyte  <= '0;
      r_wvalid <= 1'b0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wvalid <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_send) begin
            if (w_len_ok) begin
              r_hdr   <= '{dst: i_dst_addr, src: i_src_addr, d_type: i_d_type, len: i_len};
              r_pcnt  <= i_len;
              r_cnt   <= '0;
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_HDR;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (i_wready) begin
            r_wvalid <= 1'b1;
            r_wdata  <= w_hdr_byte;
            r_cnt    <= w_cnt_nxt;
            if (r_idx == 3'(MHP_HDR_LEN - 1)) begin
              r_idx   <= '0;
              r_state <= (r_hdr.len != '0) ? S_PREQ : S_CSUM;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_PREQ: begin
          if (i_pready) r_state <= S_PCAP;
        end
        S_PCAP: begin
          r_pbyte <= i_pdata;
          r_state <= S_PWR;
        end
        S_PWR: begin
          if (i_wready) begin
            r_wvalid <= 1'b1;
            r_wdata  <= r_pbyte;
            r_cnt    <= w_cnt_nxt;
            r_pcnt   <= r_pcnt - 16'd1;
            r_state  <= (r_pcnt == 16'd1) ? S_CSUM : S_PREQ;
          end
        end
        S_CSUM: begin
          if (i_wready) begin
            r_wvalid <= 1'b1;
            r_wdata  <= w_scs_byte;
            r_cnt    <= w_cnt_nxt;
            if (r_idx == 3'(MHP_SCS_LEN - 1)) begin
              r_idx   <= '0;
              r_state <= (w_cnt_nxt < 16'(MIN_FRAME)) ? S_PAD : S_FIN;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_PAD: begin
          if (i_wready) begin
            r_wvalid <= 1'b1;
            r_wdata  <= 8'h00;
            r_cnt    <= w_cnt_nxt;
            if (w_cnt_nxt >= 16'(MIN_FRAME)) r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mhp_tx.sv
// Directed bench for mhp_tx: captures every written byte and compares
// frames against hand-computed vectors and a small frame model.
module tb_mhp_tx;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_send = 1'b0;
  logic [15:0] i_dst_addr = '0;
  logic [15:0] i_src_addr = '0;
  logic [7:0]  i_d_type = '0;
  logic [15:0] i_len = '0;
  logic        i_pready;
  logic        o_preq;
  logic [7:0]  i_pdata = '0;
  logic        i_wready = 1'b1;
  logic        o_wvalid;
  logic [7:0]  o_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  bq_t  cap;
  int   preq_cnt = 0, done_cnt = 0, err_cnt = 0, viol_cnt = 0;
  logic [7:0] pay_mem [0:63];
  int   pidx = 0;
  logic wtoggle = 1'b0;
  logic pready_en = 1'b1;

  assign i_pready = pready_en;

  mhp_tx #(.MIN_FRAME(46), .MAX_LEN(1024)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_send     (i_send),
    .i_dst_addr (i_dst_addr),
    .i_src_addr (i_src_addr),
    .i_d_type   (i_d_type),
    .i_len      (i_len),
    .i_pready   (i_pready),
    .o_preq     (o_preq),
    .i_pdata    (i_pdata),
    .i_wready   (i_wready),
    .o_wvalid   (o_wvalid),
    .o_wdata    (o_wdata),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) i_wready = wtoggle ? ~i_wready : 1'b1;

  // Payload FIFO model plus output monitor.
  always @(posedge clk) begin : mon
    logic w_edge;
    logic p_edge;
    w_edge = i_wready;
    p_edge = o_preq;
    if (p_edge) begin
      i_pdata <= pay_mem[pidx];
      pidx = pidx + 1;
    end
    #1;
    if (p_edge) preq_cnt++;
    if (o_wvalid) begin
      cap.push_back(o_wdata);
      if (!w_edge) viol_cnt++;
    end
    if (o_done) done_cnt++;
    if (o_err) err_cnt++;
  end

  function automatic bq_t model(input logic [15:0] d, input logic [15:0] s,
                                input logic [7:0] t, input logic [15:0] l);
    bq_t q;
    logic [15:0] sum;
    sum = '0;
    q = '{d[15:8], d[7:0], s[15:8], s[7:0], l[15:8], l[7:0], t};
    for (int i = 0; i < 7; i++) sum = sum + {8'h00, q[i]};
    for (int i = 0; i < int'(l); i++) begin
      q.push_back(pay_mem[i]);
      sum = sum + {8'h00, pay_mem[i]};
    end
    q.push_back(sum[15:8]);
    q.push_back(sum[7:0]);
    while (q.size() < 46) q.push_back(8'h00);
    return q;
  endfunction

  function automatic int first_diff(input bq_t a, input bq_t b);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  task automatic clear_mon();
    cap.delete();
    preq_cnt = 0; done_cnt = 0; err_cnt = 0; viol_cnt = 0; pidx = 0;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] s,
                      input logic [7:0] t, input logic [15:0] l);
    @(negedge clk);
    i_dst_addr = d; i_src_addr = s; i_d_type = t; i_len = l; i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_cnt >= 1) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({o_wvalid, o_wdata, o_busy, o_done, o_err, o_preq} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h, expected 0",
               {o_wvalid, o_wdata, o_busy, o_done, o_err, o_preq});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_busy, o_wvalid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got %0b, expected 00", {o_busy, o_wvalid});
    end
  endtask

  task automatic test_basic();
    bq_t exp;
    bit  ok;
    int  fd;
    clear_mon();
    pay_mem[0] = 8'h01; pay_mem[1] = 8'h02; pay_mem[2] = 8'h03;
    exp = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h03, 8'h81, 8'h01, 8'h02, 8'h03, 8'h02, 8'h48};
    for (int i = 0; i < 34; i++) exp.push_back(8'h00);
    send(16'h1234, 16'hABCD, 8'h81, 16'd3);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b, expected 1", o_busy); end
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got no o_done, expected o_done"); end
    fd = first_diff(cap, exp);
    checks++;
    if (fd != -1) begin
      errors++;
      $display("FAIL basic_bytes: idx %0d got %0h (len %0d), expected %0h (len 46)",
               fd, cap[fd], cap.size(), exp[fd]);
    end
    checks++;
    if (preq_cnt !== 3) begin errors++; $display("FAIL basic_preq: got %0d, expected 3", preq_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL basic_done: got %0d, expected 1", done_cnt); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %0b, expected 0", o_busy); end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_mon();
    send(16'h0000, 16'h0000, 8'h00, 16'd0);
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout: got no o_done, expected o_done"); end
    checks++;
    if (cap.size() !== 46) begin errors++; $display("FAIL zero_len_count: got %0d, expected 46", cap.size()); end
    for (int i = 0; i < cap.size(); i++) begin
      if (cap[i] !== 8'h00) begin
        checks++; errors++;
        $display("FAIL zero_len_byte: idx %0d got %0h, expected 00", i, cap[i]);
        break;
      end
    end
    checks++;
    if (preq_cnt !== 0) begin errors++; $display("FAIL zero_len_preq: got %0d, expected 0", preq_cnt); end
  endtask

  task automatic test_no_pad();
    bq_t exp;
    bit  ok;
    int  fd;
    clear_mon();
    for (int i = 0; i < 40; i++) pay_mem[i] = 8'h01;
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h28, 8'h05};
    for (int i = 0; i < 40; i++) exp.push_back(8'h01);
    exp.push_back(8'h00);
    exp.push_back(8'h5F);
    send(16'h0102, 16'h0304, 8'h05, 16'd40);
    wait_done(600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nopad_timeout: got no o_done, expected o_done"); end
    checks++;
    if (cap.size() !== 49) begin errors++; $display("FAIL nopad_count: got %0d, expected 49", cap.size()); end
    fd = first_diff(cap, exp);
    checks++;
    if (fd != -1) begin
      errors++;
      $display("FAIL nopad_bytes: idx %0d got %0h, expected %0h", fd, cap[fd], exp[fd]);
    end
    checks++;
    if (preq_cnt !== 40) begin errors++; $display("FAIL nopad_preq: got %0d, expected 40", preq_cnt); end
  endtask

  task automatic test_backpressure();
    bq_t exp;
    bit  ok;
    int  fd;
    int  preq0, cap0;
    clear_mon();
    for (int i = 0; i < 8; i++) pay_mem[i] = 8'hA0 + 8'(i);
    exp = model(16'h1234, 16'hABCD, 8'h81, 16'd8);
    wtoggle = 1'b1;
    send(16'h1234, 16'hABCD, 8'h81, 16'd8);
    for (int c = 0; c < 200 && cap.size() < 10; c++) @(negedge clk);
    pready_en = 1'b0;
    preq0 = preq_cnt;
    repeat (10) @(negedge clk);
    cap0 = cap.size();
    checks++;
    if (preq_cnt !== preq0) begin
      errors++;
      $display("FAIL bp_stall_preq: got %0d, expected %0d", preq_cnt, preq0);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (cap.size() !== cap0) begin
      errors++;
      $display("FAIL bp_stall_writes: got %0d, expected %0d", cap.size(), cap0);
    end
    pready_en = 1'b1;
    wait_done(1000, ok);
    wtoggle = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: got no o_done, expected o_done"); end
    fd = first_diff(cap, exp);
    checks++;
    if (fd != -1) begin
      errors++;
      $display("FAIL bp_bytes: idx %0d got %0h, expected %0h", fd, cap[fd], exp[fd]);
    end
    checks++;
    if (viol_cnt !== 0) begin errors++; $display("FAIL bp_wready: got %0d, expected 0", viol_cnt); end
    checks++;
    if (preq_cnt !== 8) begin errors++; $display("FAIL bp_preq: got %0d, expected 8", preq_cnt); end
  endtask

  task automatic test_err_busy();
    bq_t exp;
    bit  ok;
    int  fd;
    clear_mon();
    send(16'h0001, 16'h0002, 8'h03, 16'd1025);
    checks++;
    if ({o_err, o_busy} !== 2'b10) begin
      errors++;
      $display("FAIL err_pulse: got %0b, expected 10", {o_err, o_busy});
    end
    @(negedge clk);
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL err_width: got %0b, expected 0", o_err); end
    repeat (5) @(negedge clk);
    checks++;
    if (cap.size() !== 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL err_nowrite: got %0d writes busy %0b, expected 0 writes busy 0", cap.size(), o_busy);
    end
    clear_mon();
    pay_mem[0] = 8'h01; pay_mem[1] = 8'h02; pay_mem[2] = 8'h03;
    exp = model(16'h1234, 16'hABCD, 8'h81, 16'd3);
    send(16'h1234, 16'hABCD, 8'h81, 16'd3);
    repeat (3) @(negedge clk);
    send(16'hFFFF, 16'hEEEE, 8'h7F, 16'd2000);
    wait_done(400, ok);
    checks++;
    if (!ok || err_cnt !== 0) begin
      errors++;
      $display("FAIL busy_ignore: got done %0b err %0d, expected done 1 err 0", ok, err_cnt);
    end
    fd = first_diff(cap, exp);
    checks++;
    if (fd != -1) begin
      errors++;
      $display("FAIL busy_bytes: idx %0d got %0h, expected %0h", fd, cap[fd], exp[fd]);
    end
  endtask

  task automatic test_reset_mid();
    bq_t exp;
    bit  ok;
    int  fd;
    clear_mon();
    for (int i = 0; i < 10; i++) pay_mem[i] = 8'h10 + 8'(i);
    send(16'h0A0B, 16'h0C0D, 8'h42, 16'd10);
    for (int c = 0; c < 200 && cap.size() < 12; c++) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %0b, expected 1", o_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_wvalid, o_wdata, o_busy, o_done, o_err, o_preq} !== 13'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got %0h, expected 0",
               {o_wvalid, o_wdata, o_busy, o_done, o_err, o_preq});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (6) @(negedge clk);
    checks++;
    if (cap.size() !== 0) begin errors++; $display("FAIL rst_mid_abandon: got %0d, expected 0", cap.size()); end
    for (int i = 0; i < 4; i++) pay_mem[i] = 8'hF0 + 8'(i);
    exp = model(16'h5555, 16'h6666, 8'h01, 16'd4);
    send(16'h5555, 16'h6666, 8'h01, 16'd4);
    wait_done(400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_timeout: got no o_done, expected o_done"); end
    fd = first_diff(cap, exp);
    checks++;
    if (fd != -1) begin
      errors++;
      $display("FAIL rst_mid_bytes: idx %0d got %0h, expected %0h", fd, cap[fd], exp[fd]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_no_pad();
    test_backpressure();
    test_err_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mhp_tx.md
Name: mhp_tx

Overview:
- Transmit side of the MHP packet protocol.
- On a send command, it builds one MHP frame and pushes it byte-by-byte into the Ethernet write FIFO. The frame is a 7-byte header, then payload pulled from an upstream payload FIFO, then a 16-bit SCS checksum trailer, then zero padding up to the Ethernet minimum payload size.
- Counterpart of the MHP receive/parse path. Sits between the control/application logic and the eth write port.

Parameters:
- MIN_FRAME, 46, minimum bytes per frame written to eth; pad bytes are appended to reach it.
- MAX_LEN, 1024, largest accepted payload length in bytes.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_send  in  1  one-cycle send command; header fields sampled in the same cycle
- i_dst_addr  in  16  destination address
- i_src_addr  in  16  source address
- i_d_type  in  8  bit7 = direction, bits 6:0 = packet type
- i_len  in  16  payload length in bytes
- i_pready  in  1  payload FIFO holds at least one byte
- o_preq  out  1  payload read strobe (one-cycle pulse)
- i_pdata  in  8  payload byte, valid the cycle after o_preq
- i_wready  in  1  eth write FIFO can accept a byte
- o_wvalid  out  1  write strobe (one-cycle pulse)
- o_wdata  out  8  byte to write
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse after the last frame byte
- o_err  out  1  one-cycle pulse when a send is rejected

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs go to 0 immediately; state returns to IDLE.
  - A frame in flight is abandoned; no further bytes are written.
- Byte order on the wire:
  - dst[15:8], dst[7:0], src[15:8], src[7:0], len[15:8], len[7:0], d_type.
  - Then payload[0..len-1], then scs[15:8], scs[7:0].
  - Then 0x00 pad bytes while the byte count is below MIN_FRAME.
- SCS: 16-bit sum modulo 2^16 of all header bytes and payload bytes. SCS bytes and pad bytes are excluded. The accumulator clears at frame start.
- Write handshake:
  - On a rising edge where a byte is pending and i_wready=1, the block registers o_wvalid=1 and o_wdata=byte for exactly one cycle.
  - If i_wready=0, the block holds the byte and o_wvalid stays 0. There is no timeout.
  - Back-to-back writes are allowed for header, SCS and pad bytes.
- Payload handshake:
  - o_preq pulses only when i_pready=1.
  - The byte is captured from i_pdata the following cycle.
  - Only one read is outstanding at a time.
  - i_pready=0 stalls the frame indefinitely.
- States:
  - IDLE: on i_send with i_len<=MAX_LEN, latch fields, clear the accumulator and byte counter, set o_busy, go to HDR. On i_send with i_len>MAX_LEN, pulse o_err and stay in IDLE.
  - HDR: emit header bytes 0-6. After byte 6, go to PREQ if len>0, else to CSUM.
  - PREQ: wait for i_pready, pulse o_preq, go to PCAP.
  - PCAP: capture i_pdata and add it to the SCS, go to PWR.
  - PWR: emit the captured byte. Go to PREQ while payload bytes remain, else to CSUM.
  - CSUM: emit the two SCS bytes, then go to PAD if count<MIN_FRAME, else to FIN.
  - PAD: emit 0x00 until count==MIN_FRAME, then go to FIN.
  - FIN: pulse o_done, clear o_busy, return to IDLE.
- Byte counter is 16 bits and counts every written byte. It does not wrap: the largest frame is MAX_LEN+9.
- i_send while o_busy is ignored (no o_err).
- len>=MIN_FRAME-9 produces no pad bytes.
- i_send in the same cycle as FIN is ignored. The next send is accepted from IDLE.

Decomposition:
- Shared package mhp_pkg:
  - MHP_HDR_LEN=7, MHP_SCS_LEN=2, ETH_MIN_PAYLOAD=46.
  - Direction bit index 7 and type field 6:0.
  - Header byte offset constants.
  - TX state encoding.
- Sub-module mhp_scs_acc: 16-bit checksum accumulator with clear/add-byte/value ports. It is shared with the receive-side checker.

Test Plan:
- Basic frame: dst=0x1234, src=0xABCD, len=3, d_type=0x81, payload 01 02 03, i_wready=1.
  Required: 46 writes in order 12 34 AB CD 00 03 81 01 02 03 02 48, then 34×00. o_done pulses once; o_preq pulses exactly 3 times.
- len=0, dst=src=0, d_type=0x00 -> 00 00 00 00 00 00 00, SCS 00 00, then 37 pad bytes. Total 46; no o_preq.
- len=40 with payload all 0x01 -> 49 bytes total, no padding. SCS = 0x0028 + header byte sum.
- Backpressure: toggle i_wready 1/0 each cycle, and hold i_pready=0 for 10 cycles mid-payload. Required: the byte sequence is identical to the unstalled run; o_wvalid is never high while i_wready was low at the sampling edge.
- i_len=MAX_LEN+1 -> o_err pulses 1 cycle, no o_wvalid, o_busy stays 0. A second i_send during o_busy is ignored.
- Assert i_rst_n=0 after 5 payload bytes. Required: outputs go to 0 asynchronously. After release, a new send produces a complete correct frame with a fresh SCS.
